// File: rtl/bit_scan_pkg.sv
// Shared types and constants for the bit index scanner.
package bit_scan_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic MODE_LOG2 = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/bit_index_scanner_prio_enc.sv
// Combinational priority encoder: highest (msb_first=1) or lowest set-bit index.
module prio_enc #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             msb_first,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Later loop iterations override earlier ones, so the loop order sets the priority.
  always_comb begin
    idx = '0;
    any = |vec;
    if (msb_first) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int unsigned i = WIDTH; i > 0; i--) begin
        if (vec[i-1]) idx = IDX_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/bit_index_scanner.sv
// Encodes an accepted vector as one log2 beat or a stream of set-bit indices (LSB first).
module bit_index_scanner
  import bit_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic             mode_q;

  logic [WIDTH-1:0] cleared;
  logic [WIDTH-1:0] enc_vec;
  logic             enc_msb;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;

  function automatic logic at_most_one(input logic [WIDTH-1:0] v);
    return (v & (v - ONE)) == '0;
  endfunction

  // One encoder serves both the first beat (from in_data) and every following
  // scan beat (from rem with the current bit already removed).
  always_comb begin
    cleared = rem & ~(ONE << out_idx);
    if (state == IDLE) begin
      enc_vec = in_data;
      enc_msb = (in_mode == MODE_LOG2);
    end else begin
      enc_vec = cleared;
      enc_msb = 1'b0;
    end
  end

  prio_enc #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_prio_enc (
    .vec      (enc_vec),
    .msb_first(enc_msb),
    .idx      (enc_idx),
    .any      (enc_any)
  );

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      mode_q    <= MODE_LOG2;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= EMIT;
            rem       <= in_data;
            mode_q    <= in_mode;
            out_valid <= 1'b1;
            out_idx   <= enc_idx;
            out_zero  <= !enc_any;
            out_last  <= (in_mode == MODE_LOG2) || at_most_one(in_data);
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last || mode_q == MODE_LOG2) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end else begin
              rem      <= cleared;
              out_idx  <= enc_idx;
              out_last <= at_most_one(cleared);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_index_scanner.sv
// Directed self-checking bench for bit_index_scanner (WIDTH=8 and WIDTH=32 instances).
module tb_bit_index_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_mode, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_last, out_zero;
  logic [2:0] out_idx;

  logic        w_in_valid, w_in_mode;
  logic [31:0] w_in_data;
  logic        w_in_ready, w_out_valid, w_out_last, w_out_zero;
  logic [4:0]  w_out_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bit_index_scanner #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .out_zero(out_zero)
  );

  bit_index_scanner #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_mode(w_in_mode),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_idx(w_out_idx),
    .out_last(w_out_last), .out_zero(w_out_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one vector for a single cycle; on return the first beat should be visible.
  task automatic send(input logic [7:0] data, input logic mode);
    check("in_ready_before_send", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = data;
    in_mode  = mode;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [2:0] idx, input logic last, input logic zero);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_idx"},   out_idx,   idx);
    check({tag, "_last"},  out_last,  last);
    check({tag, "_zero"},  out_zero,  zero);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid_low"}, out_valid, 1'b0);
    check({tag, "_ready_high"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [2:0] exp_idx [4];
    int cnt;
    exp_idx[0] = 3'd1; exp_idx[1] = 3'd2; exp_idx[2] = 3'd4; exp_idx[3] = 3'd7;

    rst_n = 1'b0; out_ready = 1'b1;
    in_data = 8'hFF; in_mode = 1'b1;
    w_in_valid = 1'b0; w_in_data = '0; w_in_mode = 1'b0;
    // in_valid held high during reset must not be accepted
    in_valid = 1'b1;
    tick(); tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_idx",   out_idx,   3'd0);
    check("rst_out_last",  out_last,  1'b0);
    check("rst_out_zero",  out_zero,  1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_no_accept", out_valid, 1'b0);

    // Mode 0 one-hot
    send(8'b0010_0000, 1'b0);
    beat("log2_onehot", 3'd5, 1'b1, 1'b0);
    tick();
    expect_idle("log2_onehot_done");

    // Mode 0 non-one-hot resolves to the highest bit
    send(8'b0101_0011, 1'b0);
    beat("log2_multi", 3'd6, 1'b1, 1'b0);
    tick();
    expect_idle("log2_multi_done");

    // Zero vector in both modes
    send(8'h00, 1'b0);
    beat("zero_m0", 3'd0, 1'b1, 1'b1);
    tick();
    expect_idle("zero_m0_done");
    send(8'h00, 1'b1);
    beat("zero_m1", 3'd0, 1'b1, 1'b1);
    tick();
    expect_idle("zero_m1_done");

    // Scan 1001_0110, with junk offered on the input during EMIT
    send(8'b1001_0110, 1'b1);
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("scan96_b%0d", i), exp_idx[i], (i == 3), 1'b0);
      if (i < 3) begin
        in_valid = 1'b1; in_data = 8'hFF; in_mode = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    expect_idle("scan96_done");

    // Scan FF with three cycles of backpressure on beat idx=1
    send(8'hFF, 1'b1);
    beat("scanff_b0", 3'd0, 1'b0, 1'b0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("scanff_hold%0d", i), 3'd1, 1'b0, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    cnt = 1;
    for (int i = 1; i < 8; i++) begin
      beat($sformatf("scanff_b%0d", i), 3'(i), (i == 7), 1'b0);
      if (out_valid) cnt++;
      tick();
    end
    check("scanff_beats", cnt, 8);
    expect_idle("scanff_done");

    // Reset aborts a scan of F0 after beat idx=4
    send(8'hF0, 1'b1);
    beat("scanf0_b4", 3'd4, 1'b0, 1'b0);
    tick();
    beat("scanf0_b5_pending", 3'd5, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    check("abort_valid_low", out_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    expect_idle("abort_release");
    tick(); tick();
    check("abort_no_more_beats", out_valid, 1'b0);

    // Back-to-back: next acceptance right after the final handshake
    send(8'b0000_0001, 1'b1);
    beat("b2b_first", 3'd0, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 8'b1000_0000; in_mode = 1'b1;
    tick();
    check("b2b_idle_gap", out_valid, 1'b0);
    tick();
    in_valid = 1'b0;
    beat("b2b_second", 3'd7, 1'b1, 1'b0);
    tick();
    expect_idle("b2b_done");

    // WIDTH=32 instance
    check("w32_ready", w_in_ready, 1'b1);
    w_in_valid = 1'b1; w_in_data = 32'h8000_0001; w_in_mode = 1'b0;
    tick();
    w_in_valid = 1'b0;
    check("w32_log2_valid", w_out_valid, 1'b1);
    check("w32_log2_idx",   w_out_idx,   5'd31);
    check("w32_log2_last",  w_out_last,  1'b1);
    check("w32_log2_zero",  w_out_zero,  1'b0);
    tick();
    check("w32_log2_done", w_out_valid, 1'b0);
    w_in_valid = 1'b1; w_in_mode = 1'b1;
    tick();
    w_in_valid = 1'b0;
    check("w32_scan_idx0",  w_out_idx,  5'd0);
    check("w32_scan_last0", w_out_last, 1'b0);
    tick();
    check("w32_scan_idx1",  w_out_idx,  5'd31);
    check("w32_scan_last1", w_out_last, 1'b1);
    tick();
    check("w32_scan_done", w_out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
